// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM bus bundle for ram_arbiter
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_ack_o;
    logic [DATA_WIDTH-1:0] if_data_o;
    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_wdata_i;
    logic                  mem_ack_o;
    logic [DATA_WIDTH-1:0] mem_rdata_o;
    logic                  ram_en_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic                  stall_if_o;
    logic                  stall_mem_o;
    logic                  busy_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        output if_ack_o, if_data_o, mem_ack_o, mem_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output stall_if_o, stall_mem_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        input  if_ack_o, if_data_o, mem_ack_o, mem_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  stall_if_o, stall_mem_o, busy_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - IF/MEM single-port RAM arbiter; ARB_ROUND_ROBIN_EN selects round-robin
module ram_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [2:0] LAT = 3'(RAM_LATENCY);

    state_t                r_state;
    state_t                w_next;
    logic                  r_grant_mem;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [2:0]            r_wait_cnt;
    logic                  w_any;
    logic                  w_mem_wins;
    logic                  w_issue;
    logic                  w_ack;

    assign w_any = bus.if_req_i | bus.mem_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_mem;

    always_comb begin
        w_mem_wins = bus.mem_req_i;
        if (bus.if_req_i && bus.mem_req_i) begin
            w_mem_wins = ~r_last_mem;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_mem <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_last_mem <= w_mem_wins;
        end
    end
`else
    localparam logic [2:0] STARVE_Q = 3'(STARVE_MAX);

    logic [2:0] r_starve_cnt;

    // MEM has priority unless IF has already lost STARVE_MAX arbitrations in a row.
    assign w_mem_wins = bus.mem_req_i & ~(bus.if_req_i & (r_starve_cnt == STARVE_Q));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_starve_cnt <= 3'd0;
        end else if (r_state == S_IDLE) begin
            if (!bus.if_req_i || !w_mem_wins) begin
                r_starve_cnt <= 3'd0;
            end else if (r_starve_cnt != STARVE_Q) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
            S_WAIT:  if (r_wait_cnt == 3'd1) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_grant_mem <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_wait_cnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_mem <= w_mem_wins;
                        r_we        <= w_mem_wins & bus.mem_we_i;
                        r_addr      <= w_mem_wins ? bus.mem_addr_i : bus.if_addr_i;
                        r_wdata     <= w_mem_wins ? bus.mem_wdata_i : '0;
                    end
                end
                S_ISSUE: r_wait_cnt <= LAT;
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                    if (r_wait_cnt == 3'd1) begin
                        r_rdata <= bus.ram_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_issue = (r_state == S_ISSUE);
    assign w_ack   = (r_state == S_ACK);

    assign bus.ram_en_o    = w_issue;
    assign bus.ram_we_o    = w_issue & r_we;
    assign bus.ram_addr_o  = w_issue ? r_addr : '0;
    assign bus.ram_wdata_o = w_issue ? r_wdata : '0;

    assign bus.if_ack_o    = w_ack & ~r_grant_mem;
    assign bus.mem_ack_o   = w_ack & r_grant_mem;
    assign bus.if_data_o   = bus.if_ack_o ? r_rdata : '0;
    assign bus.mem_rdata_o = (bus.mem_ack_o && !r_we) ? r_rdata : '0;

    assign bus.stall_if_o  = bus.if_req_i & ~bus.if_ack_o;
    assign bus.stall_mem_o = bus.mem_req_i & ~bus.mem_ack_o;
    assign bus.busy_o      = (r_state != S_IDLE);
endmodule
